// File: rtl/seq_mul_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mul_ctrl
// Sequencing controller for the shift-add multiplier. It captures both
// operands when a start request is accepted, then runs one add/shift
// iteration per clock over a combined accumulator/multiplier register. After
// WIDTH iterations it presents the 2*WIDTH-bit product together with a
// one-cycle done pulse.
//
// Parameters
//   WIDTH         operand width in bits (>= 2); the product is 2*WIDTH bits
//
// Ports
//   clk           system clock; all state changes on the rising edge
//   reset         synchronous, active-high reset
//   start         request; sampled only while busy=0
//   multiplicand  operand A, captured when start is accepted
//   multiplier    operand B, captured when start is accepted
//   busy          high while an operation is in progress
//   done          one-cycle pulse; product is valid in the same cycle
//   product       result; held until the next accepted start
//   step          number of iterations completed in the current operation
//
// Build option
//   SEQ_MUL_EARLY_TERM_EN  when defined, the operation finishes early once
//                          the remaining multiplier bits are all zero. The
//                          product is bit-identical to the full-length run.
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | one add/shift iteration per clock
// ---------------------------------------------------------------------------
module seq_mul_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       multiplicand,
  input  logic [WIDTH-1:0]       multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [$clog2(WIDTH):0] step
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a;
  logic [2*WIDTH:0]  p;
  logic [CW-1:0]     cnt;

  logic [WIDTH:0]    sum;
  logic [2*WIDTH:0]  p_iter;

`ifdef SEQ_MUL_EARLY_TERM_EN
  logic [WIDTH-1:0]  mrem;
  logic [CW-1:0]     shamt;
  logic [2*WIDTH:0]  p_flush;
`endif

  // Carry from the add lands in the top accumulator bit after the shift,
  // so it is never lost.
  always_comb begin
    sum    = {1'b0, p[2*WIDTH-1:WIDTH]} +
             (p[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
    p_iter = {1'b0, sum, p[WIDTH-1:1]};
  end

`ifdef SEQ_MUL_EARLY_TERM_EN
  // With no multiplier bits left, every remaining iteration would only
  // shift, so all of those shifts are applied in one step.
  always_comb begin
    shamt   = CW'(WIDTH) - cnt;
    p_flush = p >> shamt;
  end
`endif

  assign step = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      a       <= '0;
      p       <= '0;
`ifdef SEQ_MUL_EARLY_TERM_EN
      mrem    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a     <= multiplicand;
            p     <= {{(WIDTH+1){1'b0}}, multiplier};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SEQ_MUL_EARLY_TERM_EN
            mrem  <= multiplier;
`endif
          end
        end

        RUN: begin
`ifdef SEQ_MUL_EARLY_TERM_EN
          if (mrem == '0) begin
            p       <= p_flush;
            product <= p_flush[2*WIDTH-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            mrem <= mrem >> 1;
            p    <= p_iter;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              product <= p_iter[2*WIDTH-1:0];
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
`else
          p   <= p_iter;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            product <= p_iter[2*WIDTH-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
`endif
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
module tb_seq_mul_ctrl;
  localparam int W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [W-1:0]      multiplicand;
  logic [W-1:0]      multiplier;
  logic              busy;
  logic              done;
  logic [2*W-1:0]    product;
  logic [$clog2(W):0] step;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_mul_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .step         (step)
  );

  // Called at a falling edge with the DUT idle. Raises start for one edge,
  // scrambles the operands right after capture, optionally re-pulses start at
  // negedge inj_cyc, and returns the number of edges (accept edge counted as 1)
  // until done is seen, or -1 if done never arrives.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj_cyc,
                        input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output int edges, output int busy_cnt,
                        output logic [2*W-1:0] prod,
                        output logic [$clog2(W):0] st);
    edges    = -1;
    busy_cnt = 0;
    prod     = 'x;
    st       = 'x;
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start        = 1'b0;
        multiplicand = 16'hA5A5;
        multiplier   = 16'h5A5A;
      end
      if (inj_cyc != 0 && i == inj_cyc) begin
        start        = 1'b1;
        multiplicand = ia;
        multiplier   = ib;
      end
      if (inj_cyc != 0 && i == inj_cyc + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        edges = i;
        prod  = product;
        st    = step;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (product !== 32'h0) begin bad++; $display("FAIL reset_product got=%h exp=0", product); end
    total++; if (step !== 5'd0) begin bad++; $display("FAIL reset_step got=%0d exp=0", step); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e, bc;
    logic [2*W-1:0] pr;
    logic [$clog2(W):0] st;
    run_op(16'd3, 16'd5, 0, '0, '0, e, bc, pr, st);
    total++; if (pr !== 32'h0000000F) begin bad++; $display("FAIL basic_product got=%h exp=0000000f", pr); end
    total++; if (e !== 17) begin bad++; $display("FAIL basic_latency got=%0d exp=17", e); end
    total++; if (bc !== 16) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=16", bc); end
    total++; if (st !== 5'd16) begin bad++; $display("FAIL basic_step_done got=%0d exp=16", st); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    total++; if (product !== 32'h0000000F) begin bad++; $display("FAIL basic_product_hold got=%h exp=0000000f", product); end
  endtask

  task automatic test_carry();
    int e, bc;
    logic [2*W-1:0] pr;
    logic [$clog2(W):0] st;
    run_op(16'hFFFF, 16'hFFFF, 0, '0, '0, e, bc, pr, st);
    total++; if (pr !== 32'hFFFE0001) begin bad++; $display("FAIL carry_product got=%h exp=fffe0001", pr); end
    total++; if (e !== 17) begin bad++; $display("FAIL carry_latency got=%0d exp=17", e); end
  endtask

  task automatic test_patterns();
    logic [W-1:0]   ta [4] = '{16'h8000, 16'hFFFF, 16'h00AB, 16'h0000};
    logic [W-1:0]   tb [4] = '{16'h8000, 16'h0001, 16'h00CD, 16'hBEEF};
    logic [2*W-1:0] tp [4] = '{32'h40000000, 32'h0000FFFF, 32'h000088EF, 32'h00000000};
    int e, bc;
    logic [2*W-1:0] pr;
    logic [$clog2(W):0] st;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], 0, '0, '0, e, bc, pr, st);
      total++; if (pr !== tp[i]) begin bad++; $display("FAIL pattern%0d_product got=%h exp=%h", i, pr, tp[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    int e, bc;
    logic [2*W-1:0] pr;
    logic [$clog2(W):0] st;
    run_op(16'h1234, 16'h0002, 5, 16'hFFFF, 16'hFFFF, e, bc, pr, st);
    total++; if (pr !== 32'h00002468) begin bad++; $display("FAIL busy_start_product got=%h exp=00002468", pr); end
    total++; if (e !== 17) begin bad++; $display("FAIL busy_start_latency got=%0d exp=17", e); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_no_restart got=%b exp=0", busy); end
  endtask

  task automatic test_reset_abort();
    int e, bc, dcnt;
    logic [2*W-1:0] pr;
    logic [$clog2(W):0] st;
    start        = 1'b1;
    multiplicand = 16'h00FF;
    multiplier   = 16'h0100;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (product !== 32'h0) begin bad++; $display("FAIL abort_product got=%h exp=0", product); end
    total++; if (step !== 5'd0) begin bad++; $display("FAIL abort_step got=%0d exp=0", step); end
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dcnt); end
    run_op(16'h0002, 16'h0003, 0, '0, '0, e, bc, pr, st);
    total++; if (pr !== 32'h00000006) begin bad++; $display("FAIL abort_next_product got=%h exp=00000006", pr); end
    total++; if (e !== 17) begin bad++; $display("FAIL abort_next_latency got=%0d exp=17", e); end
  endtask

  task automatic test_back_to_back();
    int e, bc;
    logic [2*W-1:0] pr;
    logic [$clog2(W):0] st;
    run_op(16'd5, 16'd6, 0, '0, '0, e, bc, pr, st);
    total++; if (pr !== 32'h0000001E) begin bad++; $display("FAIL b2b_first_product got=%h exp=0000001e", pr); end
    // still in the done cycle: issue the next operation immediately
    run_op(16'd7, 16'd9, 0, '0, '0, e, bc, pr, st);
    total++; if (pr !== 32'h0000003F) begin bad++; $display("FAIL b2b_second_product got=%h exp=0000003f", pr); end
    total++; if (e !== 17) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=17", e); end
    @(negedge clk);
  endtask

  task automatic test_early_term();
    int e, bc;
    int exp_e0, exp_e1, exp_s0, exp_s1;
    logic [2*W-1:0] pr;
    logic [$clog2(W):0] st;
`ifdef SEQ_MUL_EARLY_TERM_EN
    exp_e0 = 2;  exp_e1 = 3;  exp_s0 = 0;  exp_s1 = 1;
`else
    exp_e0 = 17; exp_e1 = 17; exp_s0 = 16; exp_s1 = 16;
`endif
    run_op(16'h1234, 16'h0000, 0, '0, '0, e, bc, pr, st);
    total++; if (pr !== 32'h0) begin bad++; $display("FAIL et_zero_product got=%h exp=0", pr); end
    total++; if (e !== exp_e0) begin bad++; $display("FAIL et_zero_latency got=%0d exp=%0d", e, exp_e0); end
    total++; if (int'(st) !== exp_s0) begin bad++; $display("FAIL et_zero_step got=%0d exp=%0d", st, exp_s0); end
    run_op(16'h1234, 16'h0001, 0, '0, '0, e, bc, pr, st);
    total++; if (pr !== 32'h00001234) begin bad++; $display("FAIL et_one_product got=%h exp=00001234", pr); end
    total++; if (e !== exp_e1) begin bad++; $display("FAIL et_one_latency got=%0d exp=%0d", e, exp_e1); end
    total++; if (int'(st) !== exp_s1) begin bad++; $display("FAIL et_one_step got=%0d exp=%0d", st, exp_s1); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_patterns();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_early_term();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
